// File: rtl/debug_dump_collector_pkg.sv
// Shared types and defaults for the debug dump collector: FSM states, section codes
// and the default parameter values.
package debug_dump_collector_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PC,
    ST_REGS,
    ST_MEM,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [1:0] SEC_PC  = 2'd0;
  localparam logic [1:0] SEC_REG = 2'd1;
  localparam logic [1:0] SEC_MEM = 2'd2;

  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_DATA_WIDTH_UART = 8;
  localparam int DEF_N_REGS          = 32;
  localparam int DEF_N_MEM           = 32;
  localparam int DEF_TIMEOUT_CYCLES  = 65536;

  // Index width wide enough for the larger section, never narrower than one bit.
  function automatic int idx_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/debug_dump_collector_byte_word_assembler.sv
// Collects little-endian bytes into a word; the first byte lands in the low bits and
// a registered ready pulse follows the strobe of the word's last byte.
module byte_word_assembler #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_byte_valid,
  input  logic [BYTE_WIDTH-1:0] i_byte,
  output logic                  o_last_byte,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_word_ready
);

  localparam int N_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int CW      = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_BYTES - 1);

  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_word_ready;
  logic [DATA_WIDTH-1:0] w_shift_next;

  generate
    if (N_BYTES == 1) begin : g_single
      assign w_shift_next = i_byte;
    end else begin : g_multi
      assign w_shift_next = {i_byte, r_shift[DATA_WIDTH-1:BYTE_WIDTH]};
    end
  endgenerate

  assign o_last_byte  = i_byte_valid && (r_count == LAST);
  assign o_word       = r_word;
  assign o_word_ready = r_word_ready;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count      <= '0;
      r_shift      <= '0;
      r_word       <= '0;
      r_word_ready <= 1'b0;
    end else begin
      r_word_ready <= 1'b0;
      if (i_clear) begin
        r_count <= '0;
        r_shift <= '0;
      end else if (i_byte_valid) begin
        r_shift <= w_shift_next;
        if (o_last_byte) begin
          r_count      <= '0;
          r_word       <= w_shift_next;
          r_word_ready <= 1'b1;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debug_dump_collector.sv
// Collects one debug dump frame (PC, registers, memory) from a UART byte stream.
// Optional trailing XOR checksum byte is enabled by defining DUMP_CHECKSUM_EN.
module debug_dump_collector
  import debug_dump_collector_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int DATA_WIDTH_UART = DEF_DATA_WIDTH_UART,
  parameter int N_REGS          = DEF_N_REGS,
  parameter int N_MEM           = DEF_N_MEM,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                                   i_clock,
  input  logic                                   i_reset,
  input  logic                                   i_start,
  input  logic                                   i_rx_done,
  input  logic [DATA_WIDTH_UART-1:0]             i_rx_byte,
  output logic                                   o_word_valid,
  output logic [DATA_WIDTH-1:0]                  o_word,
  output logic [1:0]                             o_section,
  output logic [idx_width(N_REGS, N_MEM)-1:0]    o_index,
  output logic                                   o_busy,
  output logic                                   o_frame_done,
  output logic                                   o_error
);

  localparam int IW = idx_width(N_REGS, N_MEM);
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] REG_LAST = IW'(N_REGS - 1);
  localparam logic [IW-1:0] MEM_LAST = IW'(N_MEM - 1);

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_cnt;
  logic [GW-1:0] r_gap;
  logic [1:0]    r_section;
  logic [IW-1:0] r_index;
  logic          r_error;
  logic          r_frame_done;
  logic          w_collect;
  logic          w_wait;
  logic          w_start;
  logic          w_byte;
  logic          w_timeout;
  logic          w_last;
  logic          w_sec_end;
  logic          w_csum_bad;
  logic [1:0]    w_cur_sec;

  // Byte interface: i_rx_done is a one-cycle strobe qualifying i_rx_byte, no backpressure.
  // Word interface: o_word_valid is a one-cycle strobe; word/section/index hold until the next.
  assign w_collect = (r_state == ST_PC) || (r_state == ST_REGS) || (r_state == ST_MEM);
  assign w_wait    = w_collect || (r_state == ST_CHECK);
  assign w_start   = (r_state == ST_IDLE) && i_start;
  assign w_byte    = w_collect && i_rx_done;
  assign w_timeout = w_wait && !i_rx_done && (r_gap == GAP_LAST);

  byte_word_assembler #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (DATA_WIDTH_UART)
  ) u_asm (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (w_start || w_timeout),
    .i_byte_valid (w_byte),
    .i_byte       (i_rx_byte),
    .o_last_byte  (w_last),
    .o_word       (o_word),
    .o_word_ready (o_word_valid)
  );

  always_comb begin
    w_cur_sec = SEC_PC;
    w_sec_end = 1'b0;
    case (r_state)
      ST_PC:   begin w_cur_sec = SEC_PC;  w_sec_end = 1'b1;               end
      ST_REGS: begin w_cur_sec = SEC_REG; w_sec_end = (r_cnt == REG_LAST); end
      ST_MEM:  begin w_cur_sec = SEC_MEM; w_sec_end = (r_cnt == MEM_LAST); end
      default: begin w_cur_sec = SEC_PC;  w_sec_end = 1'b0;               end
    endcase
  end

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_WIDTH_UART-1:0] r_csum;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)     r_csum <= '0;
    else if (w_start) r_csum <= '0;
    else if (w_byte)  r_csum <= r_csum ^ i_rx_byte;
  end

  assign w_csum_bad = (r_state == ST_CHECK) && i_rx_done && (i_rx_byte != r_csum);
`else
  assign w_csum_bad = 1'b0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_timeout) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (i_start) w_next = ST_PC;
        ST_PC:    if (w_last) w_next = ST_REGS;
        ST_REGS:  if (w_last && w_sec_end) w_next = ST_MEM;
`ifdef DUMP_CHECKSUM_EN
        ST_MEM:   if (w_last && w_sec_end) w_next = ST_CHECK;
        ST_CHECK: if (i_rx_done) w_next = ST_DONE;
`else
        ST_MEM:   if (w_last && w_sec_end) w_next = ST_DONE;
`endif
        ST_DONE:  w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_gap        <= '0;
      r_section    <= SEC_PC;
      r_index      <= '0;
      r_error      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_timeout || (w_next == ST_DONE);

      if (w_start || w_timeout) r_cnt <= '0;
      else if (w_last)          r_cnt <= w_sec_end ? '0 : r_cnt + 1'b1;

      // The gap counter only runs while a frame is waiting on bytes.
      if (w_start || i_rx_done || !w_wait) r_gap <= '0;
      else                                  r_gap <= r_gap + 1'b1;

      if (w_last) begin
        r_section <= w_cur_sec;
        r_index   <= r_cnt;
      end

      if (w_start)                      r_error <= 1'b0;
      else if (w_timeout || w_csum_bad) r_error <= 1'b1;
    end
  end

  assign o_section    = r_section;
  assign o_index      = r_index;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_frame_done = r_frame_done;
  assign o_error      = r_error;

endmodule

// File: tb/tb_debug_dump_collector.sv
// Directed bench for debug_dump_collector: default-size frame collector plus a
// small 16-bit instance; honours DUMP_CHECKSUM_EN when defined.
module tb_debug_dump_collector;

  localparam int TO = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // clock / reset
  always #5 clk = ~clk;

  logic        start_a, rxd_a, wv_a, busy_a, done_a, err_a;
  logic [7:0]  rxb_a;
  logic [31:0] word_a;
  logic [1:0]  sec_a;
  logic [4:0]  idx_a;

  logic        start_b, rxd_b, wv_b, busy_b, done_b, err_b;
  logic [7:0]  rxb_b;
  logic [15:0] word_b;
  logic [1:0]  sec_b;
  logic [1:0]  idx_b;

  int checks = 0;
  int errors = 0;
  int n_words_a = 0, n_done_a = 0, n_words_b = 0, n_done_b = 0;
  int w0, d0;

  logic [38:0] exp_q[$];
  logic [19:0] exp_q_b[$];
  logic [38:0] e_a;
  logic [19:0] e_b;

  debug_dump_collector #(
    .DATA_WIDTH(32), .DATA_WIDTH_UART(8), .N_REGS(32), .N_MEM(32), .TIMEOUT_CYCLES(TO)
  ) dut_a (
    .i_clock(clk), .i_reset(rst), .i_start(start_a), .i_rx_done(rxd_a), .i_rx_byte(rxb_a),
    .o_word_valid(wv_a), .o_word(word_a), .o_section(sec_a), .o_index(idx_a),
    .o_busy(busy_a), .o_frame_done(done_a), .o_error(err_a)
  );

  debug_dump_collector #(
    .DATA_WIDTH(16), .DATA_WIDTH_UART(8), .N_REGS(4), .N_MEM(2), .TIMEOUT_CYCLES(TO)
  ) dut_b (
    .i_clock(clk), .i_reset(rst), .i_start(start_b), .i_rx_done(rxd_b), .i_rx_byte(rxb_b),
    .o_word_valid(wv_b), .o_word(word_b), .o_section(sec_b), .o_index(idx_b),
    .o_busy(busy_b), .o_frame_done(done_b), .o_error(err_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every emitted word must match the head of its expected queue
  always @(negedge clk) begin
    if (wv_a) begin
      n_words_a++;
      e_a = '1;
      if (exp_q.size() > 0) e_a = exp_q.pop_front();
      checks++;
      assert ({sec_a, idx_a, word_a} === e_a) else begin
        errors++;
        $error("FAIL word_a got=%0h exp=%0h", {sec_a, idx_a, word_a}, e_a);
      end
    end
    if (done_a) n_done_a++;
    if (wv_b) begin
      n_words_b++;
      e_b = '1;
      if (exp_q_b.size() > 0) e_b = exp_q_b.pop_front();
      checks++;
      assert ({sec_b, idx_b, word_b} === e_b) else begin
        errors++;
        $error("FAIL word_b got=%0h exp=%0h", {sec_b, idx_b, word_b}, e_b);
      end
    end
    if (done_b) n_done_b++;
  end

  // frame content models
  function automatic logic [31:0] fw_a(input int w);
    if (w == 0)       return 32'h0000_0038;
    else if (w <= 32) return 32'(w - 1);
    else              return 32'hA500_0000 + 32'(w - 33);
  endfunction

  function automatic logic [38:0] item_a(input int w);
    logic [1:0] s;
    logic [4:0] i;
    if (w == 0)       begin s = 2'd0; i = 5'd0;       end
    else if (w <= 32) begin s = 2'd1; i = 5'(w - 1);  end
    else              begin s = 2'd2; i = 5'(w - 33); end
    return {s, i, fw_a(w)};
  endfunction

  function automatic logic [15:0] fw_b(input int w);
    if (w == 0)      return 16'h1234;
    else if (w <= 4) return 16'h0100 + 16'(w - 1);
    else             return 16'hBE00 + 16'(w - 5);
  endfunction

  function automatic logic [19:0] item_b(input int w);
    logic [1:0] s;
    logic [1:0] i;
    if (w == 0)      begin s = 2'd0; i = 2'd0;      end
    else if (w <= 4) begin s = 2'd1; i = 2'(w - 1); end
    else             begin s = 2'd2; i = 2'(w - 5); end
    return {s, i, fw_b(w)};
  endfunction

  // drivers
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_a(input logic [7:0] b);
    @(negedge clk); rxd_a = 1'b1; rxb_a = b;
    @(negedge clk); rxd_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    @(negedge clk); rxd_b = 1'b1; rxb_b = b;
    @(negedge clk); rxd_b = 1'b0;
  endtask

  task automatic pulse_start_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
  endtask

  task automatic frame_a(input int nbytes, input bit bad_csum, input bit poke_start);
    logic [31:0] w32;
    logic [7:0]  b;
    logic [7:0]  cs;
    cs = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      w32 = fw_a(i / 4);
      b = w32[8*(i%4) +: 8];
      if (i % 4 == 3) exp_q.push_back(item_a(i / 4));
      cs = cs ^ b;
      send_a(b);
      if (poke_start && i == 9) pulse_start_a();
    end
`ifdef DUMP_CHECKSUM_EN
    if (nbytes == 260) send_a(bad_csum ? ~cs : cs);
`else
    if (bad_csum) cs = 8'h00;
`endif
  endtask

  task automatic frame_b();
    logic [15:0] w16;
    logic [7:0]  b;
    logic [7:0]  cs;
    cs = 8'h00;
    for (int i = 0; i < 14; i++) begin
      w16 = fw_b(i / 2);
      b = w16[8*(i%2) +: 8];
      if (i % 2 == 1) exp_q_b.push_back(item_b(i / 2));
      cs = cs ^ b;
      send_b(b);
    end
`ifdef DUMP_CHECKSUM_EN
    send_b(cs);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_word_valid"}, 64'(wv_a), 64'd0);
    chk({tag, "_word"},       64'(word_a), 64'd0);
    chk({tag, "_section"},    64'(sec_a), 64'd0);
    chk({tag, "_index"},      64'(idx_a), 64'd0);
    chk({tag, "_busy"},       64'(busy_a), 64'd0);
    chk({tag, "_frame_done"}, 64'(done_a), 64'd0);
    chk({tag, "_error"},      64'(err_a), 64'd0);
  endtask

  task automatic check_full_frame(input string tag);
    chk({tag, "_words"}, 64'(n_words_a - w0), 64'd65);
    chk({tag, "_done"},  64'(n_done_a - d0), 64'd1);
    chk({tag, "_error"}, 64'(err_a), 64'd0);
    chk({tag, "_busy"},  64'(busy_a), 64'd0);
    chk({tag, "_queue"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    start_a = 1'b0; rxd_a = 1'b0; rxb_a = 8'h00;
    start_b = 1'b0; rxd_b = 1'b0; rxb_b = 8'h00;
    rst = 1'b1;
    tick(2);
    check_all_zero("reset");
    rst = 1'b0;
    tick(2);

    // bytes with no frame armed are dropped
    for (int i = 0; i < 5; i++) send_a(8'hC0 + 8'(i));
    tick(2);
    chk("pre_start_words", 64'(n_words_a), 64'd0);
    chk("pre_start_busy", 64'(busy_a), 64'd0);

    // start with a coincident byte strobe; the byte must be discarded
    @(negedge clk); start_a = 1'b1; rxd_a = 1'b1; rxb_a = 8'hEE;
    @(negedge clk); start_a = 1'b0; rxd_a = 1'b0;
    chk("busy_after_start", 64'(busy_a), 64'd1);
    w0 = n_words_a; d0 = n_done_a;
    frame_a(260, 1'b0, 1'b1);
    tick(3);
    check_full_frame("frame1");

    // timeout after 130 bytes: 32 complete words, partial word dropped
    pulse_start_a();
    w0 = n_words_a; d0 = n_done_a;
    frame_a(130, 1'b0, 1'b0);
    tick(TO - 20);
    chk("no_early_timeout", 64'(busy_a), 64'd1);
    for (int c = 0; c < 60 && n_done_a == d0; c++) tick(1);
    chk("to_done", 64'(n_done_a - d0), 64'd1);
    chk("to_error", 64'(err_a), 64'd1);
    chk("to_busy", 64'(busy_a), 64'd0);
    chk("to_words", 64'(n_words_a - w0), 64'd32);
    chk("to_queue", 64'(exp_q.size()), 64'd0);

    // next start clears the error; reset mid-frame abandons it silently
    pulse_start_a();
    chk("err_cleared", 64'(err_a), 64'd0);
    d0 = n_done_a;
    frame_a(10, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    #1;
    check_all_zero("midrst");
    tick(1); rst = 1'b0;
    tick(3);
    chk("midrst_no_done", 64'(n_done_a - d0), 64'd0);
    chk("midrst_busy", 64'(busy_a), 64'd0);

    pulse_start_a();
    w0 = n_words_a; d0 = n_done_a;
    frame_a(260, 1'b0, 1'b0);
    tick(3);
    check_full_frame("frame2");

`ifdef DUMP_CHECKSUM_EN
    pulse_start_a();
    w0 = n_words_a; d0 = n_done_a;
    frame_a(260, 1'b1, 1'b0);
    tick(3);
    chk("csum_bad_error", 64'(err_a), 64'd1);
    chk("csum_bad_done", 64'(n_done_a - d0), 64'd1);
    chk("csum_bad_words", 64'(n_words_a - w0), 64'd65);
`endif

    // small configuration: 7 words of 2 bytes
    pulse_start_b();
    frame_b();
    tick(3);
    chk("small_words", 64'(n_words_b), 64'd7);
    chk("small_done", 64'(n_done_b), 64'd1);
    chk("small_error", 64'(err_b), 64'd0);
    chk("small_busy", 64'(busy_b), 64'd0);
    chk("small_queue", 64'(exp_q_b.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
